// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        AC_NONE, AC_ADD, AC_SUB, AC_FUNCT, AC_IMM, AC_IMM_HOLD
    } alu_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: maps state class, opcode and funct to alu_op, ext_zero and a bad-funct flag
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_op,
    output logic        ext_zero,
    output logic        bad_funct
);
    logic logic_imm;

    assign logic_imm = opcode == OP_ANDI || opcode == OP_ORI;

    always_comb begin
        alu_op    = ALU_AND;
        ext_zero  = 1'b0;
        bad_funct = 1'b0;
        case (alu_class)
            AC_ADD: alu_op = ALU_ADD;
            AC_SUB: alu_op = ALU_SUB;
            AC_FUNCT:
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: bad_funct = 1'b1;
                endcase
            AC_IMM: begin
                alu_op   = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
                ext_zero = logic_imm;
            end
            // the writeback cycle keeps the zero-extended immediate path selected
            AC_IMM_HOLD: ext_zero = logic_imm;
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: Moore-style multicycle MIPS control FSM with shared-memory handshake
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);
    state_t     state_q, state_d;
    alu_class_t ac;
    ctrl_t      c;
    logic [3:0] dec_op;
    logic       dec_ez, bad_funct;

    assign ac = state_q inside {S_FETCH, S_DECODE, S_MEMADR} ? AC_ADD :
                state_q == S_BRANCH ? AC_SUB :
                state_q == S_EXEC   ? AC_FUNCT :
                state_q == S_IEXEC  ? AC_IMM :
                state_q == S_IWB    ? AC_IMM_HOLD : AC_NONE;

    mips_alu_dec u_alu_dec (
        .alu_class (ac),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (dec_op),
        .ext_zero  (dec_ez),
        .bad_funct (bad_funct)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_RTYPE:                  state_d = S_EXEC;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
                    OP_J:                      state_d = S_JUMP;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                state_d     = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
                state_d    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                state_d     = bad_funct ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.pc_src    = PC_ALUOUT;
                c.pc_write  = opcode == OP_BNE ? ~zero : zero;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                state_d     = S_IWB;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_JUMP;
                state_d    = S_FETCH;
            end
            S_TRAP: c.illegal = 1'b1;
            default: state_d = S_TRAP;
        endcase
        c.alu_op   = dec_op;
        c.ext_zero = dec_ez;
    end

    // outputs are gated by rst_n so an asserted reset silences the datapath at once
    assign {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, illegal} = rst_n ? c : '0;
    assign state = rst_n ? state_q : S_FETCH;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed self-checking bench for the multicycle control unit
module tb_mips_mc_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst;
    logic       mem_to_reg, alu_src_a, ext_zero, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state;
    logic [18:0] outs;
    int checks = 0, failures = 0;

    mips_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op), .illegal(illegal),
        .state(state)
    );

    assign outs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, illegal};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_RTYPE; funct = FN_ADD;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (outs !== 19'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_FETCH); end
        mem_ready = 1'b0; rst_n = 1'b1;
        #1;
        checks++; if ({mem_read, i_or_d, ir_write, pc_write} !== 4'b1000) begin failures++; $display("FAIL reset_first_fetch got=%b exp=1000", {mem_read, i_or_d, ir_write, pc_write}); end
        @(negedge clk); #1;
        checks++; if (state !== S_FETCH || mem_read !== 1'b1) begin failures++; $display("FAIL fetch_stall state=%0d mem_read=%b exp FETCH/1", state, mem_read); end
        @(negedge clk);
    endtask

    task automatic test_rtype_add();
        state_t exp_s [4] = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
        int rw = 0;
        opcode = OP_RTYPE; funct = FN_ADD; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== exp_s[i]) begin failures++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            if (i == 0) begin
                checks++; if (outs !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0010, 1'b0}) begin failures++; $display("FAIL fetch_outs got=%h", outs); end
            end
            if (i == 2) begin
                checks++; if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd0, 4'b0010}) begin failures++; $display("FAIL rtype_exec got=%b exp=1000010", {alu_src_a, alu_src_b, alu_op}); end
            end
            if (reg_write && reg_dst) rw++;
            @(negedge clk);
        end
        checks++; if (rw !== 1) begin failures++; $display("FAIL rtype_regwrite_count got=%0d exp=1", rw); end
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL rtype_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
    endtask

    task automatic test_lw_wait();
        state_t exp_s [7] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        logic rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_LW; funct = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; #1;
            checks++; if (state !== exp_s[i]) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            if (i == 2) begin
                checks++; if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd2, 4'b0010}) begin failures++; $display("FAIL lw_memadr got=%b exp=1100010", {alu_src_a, alu_src_b, alu_op}); end
            end
            if (i >= 3 && i <= 5) begin
                checks++; if ({mem_read, mem_write, i_or_d, reg_write} !== 4'b1010) begin failures++; $display("FAIL lw_memrd[%0d] got=%b exp=1010", i, {mem_read, mem_write, i_or_d, reg_write}); end
            end
            if (i == 6) begin
                checks++; if ({reg_write, reg_dst, mem_to_reg, mem_read} !== 4'b1010) begin failures++; $display("FAIL lw_memwb got=%b exp=1010", {reg_write, reg_dst, mem_to_reg, mem_read}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL lw_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
    endtask

    task automatic test_sw_wait();
        state_t exp_s [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR};
        logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; #1;
            checks++; if (state !== exp_s[i]) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
            if (i >= 3) begin
                checks++; if ({mem_read, mem_write, i_or_d, reg_write} !== 4'b0110) begin failures++; $display("FAIL sw_memwr[%0d] got=%b exp=0110", i, {mem_read, mem_write, i_or_d, reg_write}); end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL sw_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcw);
        opcode = op; zero = z; mem_ready = 1'b1;
        #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL br_fetch op=%b got=%0d", op, state); end
        @(negedge clk); #1;
        checks++; if (state !== S_DECODE || {alu_src_a, alu_src_b, alu_op} !== {1'b0, 2'd3, 4'b0010}) begin failures++; $display("FAIL br_decode state=%0d sel=%b exp DECODE/0110010", state, {alu_src_a, alu_src_b, alu_op}); end
        @(negedge clk); #1;
        checks++; if (state !== S_BRANCH || {pc_write, pc_src, alu_src_a, alu_op} !== {exp_pcw, 2'd1, 1'b1, 4'b0110}) begin failures++; $display("FAIL br_branch op=%b z=%b state=%0d got=%b exp=%b", op, z, state, {pc_write, pc_src, alu_src_a, alu_op}, {exp_pcw, 2'd1, 1'b1, 4'b0110}); end
        @(negedge clk);
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL br_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
        zero = 1'b0;
    endtask

    task automatic test_imm(input logic [5:0] op, input logic [3:0] exp_op, input logic exp_ez);
        opcode = op; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== S_IEXEC || {alu_src_a, alu_src_b, alu_op, ext_zero} !== {1'b1, 2'd2, exp_op, exp_ez}) begin failures++; $display("FAIL imm_iexec op=%b state=%0d got=%b exp=%b", op, state, {alu_src_a, alu_src_b, alu_op, ext_zero}, {1'b1, 2'd2, exp_op, exp_ez}); end
        @(negedge clk); #1;
        checks++; if (state !== S_IWB || {reg_write, reg_dst, mem_to_reg, ext_zero} !== {3'b100, exp_ez}) begin failures++; $display("FAIL imm_iwb op=%b state=%0d got=%b exp=%b", op, state, {reg_write, reg_dst, mem_to_reg, ext_zero}, {3'b100, exp_ez}); end
        @(negedge clk);
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL imm_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
    endtask

    task automatic test_jump();
        opcode = OP_J; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== S_JUMP || outs !== {4'b0000, 1'b1, 2'd2, 12'd0}) begin failures++; $display("FAIL jump state=%0d got=%h exp=%h", state, outs, {4'b0000, 1'b1, 2'd2, 12'd0}); end
        @(negedge clk);
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL jump_return got=%0d exp=%0d", state, S_FETCH); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int bad = 0;
        opcode = 6'b111111; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; #1;
            if (state !== S_TRAP || outs !== 19'd1) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL trap_hold bad_cycles=%0d exp=0", bad); end
        rst_n = 1'b0; #1;
        checks++; if (outs !== 19'd0 || state !== S_FETCH) begin failures++; $display("FAIL trap_reset outs=%h state=%0d exp 0/FETCH", outs, state); end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH || mem_read !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL trap_release state=%0d mem_read=%b illegal=%b", state, mem_read, illegal); end
        @(negedge clk);
    endtask

    task automatic test_bad_funct();
        opcode = OP_RTYPE; funct = 6'b000111; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== S_EXEC) begin failures++; $display("FAIL badfn_exec got=%0d exp=%0d", state, S_EXEC); end
        @(negedge clk); #1;
        checks++; if (state !== S_TRAP || outs !== 19'd1) begin failures++; $display("FAIL badfn_trap state=%0d outs=%h exp TRAP/1", state, outs); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; funct = FN_ADD;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        opcode = OP_SW; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== S_MEMWR || mem_write !== 1'b1) begin failures++; $display("FAIL arst_pre state=%0d mem_write=%b exp MEMWR/1", state, mem_write); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (outs !== 19'd0 || state !== S_FETCH) begin failures++; $display("FAIL arst_immediate outs=%h state=%0d exp 0/FETCH", outs, state); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (state !== S_FETCH || {mem_read, mem_write, i_or_d} !== 3'b100) begin failures++; $display("FAIL arst_release state=%0d got=%b exp=100", state, {mem_read, mem_write, i_or_d}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_sw_wait();
        test_branch(OP_BEQ, 1'b1, 1'b1);
        test_branch(OP_BNE, 1'b1, 1'b0);
        test_branch(OP_BEQ, 1'b0, 1'b0);
        test_branch(OP_BNE, 1'b0, 1'b1);
        test_imm(OP_ORI, ALU_OR, 1'b1);
        test_imm(OP_ADDI, ALU_ADD, 1'b0);
        test_imm(OP_ANDI, ALU_AND, 1'b1);
        test_jump();
        test_illegal();
        test_bad_funct();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
